// File: rtl/pe_conv1d_mf.sv
// Multi-filter 1-D convolution processing element: holds FILTER_NUM filters, streams one
// ifmap row in, and emits one psum per (output index, filter) over a valid/ready port.
module pe_conv1d_mf #(
  parameter int DATA_W       = 16,
  parameter int PSUM_W       = 16,
  parameter int CONFIG_BIT   = 5,
  parameter int FILTER_NUM   = 2,
  parameter int FILTER_DEPTH = 8,
  parameter int IFMAP_DEPTH  = 16,
  localparam int FID_W       = (FILTER_NUM > 1) ? $clog2(FILTER_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [CONFIG_BIT-1:0] filter_size,
  input  logic [CONFIG_BIT-1:0] ifmap_size,
  input  logic [CONFIG_BIT-1:0] stride,
  input  logic                  filter_wen,
  input  logic [DATA_W-1:0]     filter_din,
  output logic                  filter_ready,
  input  logic                  filter_done,
  input  logic                  start,
  input  logic                  ifmap_wen,
  input  logic [DATA_W-1:0]     ifmap_din,
  output logic                  ifmap_ready,
  output logic [PSUM_W-1:0]     psum_dout,
  output logic [FID_W-1:0]      psum_fid,
  output logic                  psum_valid,
  input  logic                  psum_ready,
  output logic                  busy,
  output logic                  cfg_err,
  output logic [2:0]            dbg_state
);

  // Handshakes: a word moves on a rising edge where en, the valid side (wen/psum_valid)
  // and the ready side are all high; a raised psum_valid holds its payload until then.
  localparam logic [2:0] IDLE = 3'd0, LOAD_F = 3'd1, WAIT_S = 3'd2,
                         LOAD_I = 3'd3, MAC = 3'd4, OUT = 3'd5;
  localparam int FA_W  = (FILTER_NUM * FILTER_DEPTH > 1) ? $clog2(FILTER_NUM * FILTER_DEPTH) : 1;
  localparam int IA_W  = (IFMAP_DEPTH > 1) ? $clog2(IFMAP_DEPTH) : 1;
  localparam int PTR_W = $clog2(FILTER_NUM * FILTER_DEPTH + 1);

  logic [2:0]            state, next;
  logic [PTR_W-1:0]      ptr;
  logic [CONFIG_BIT-1:0] fs_q, is_q, st_q, k;
  logic [CONFIG_BIT:0]   icnt, base;
  logic [FID_W-1:0]      f;
  logic [PSUM_W-1:0]     acc;
  logic [DATA_W-1:0]     fmem [2**FA_W];
  logic [DATA_W-1:0]     imem [2**IA_W];

  logic                       cfg_ok, last_k, last_f, last_o;
  logic signed [2*DATA_W-1:0] prod;

  assign cfg_ok = (filter_size != '0) && (stride != '0) &&
                  (int'(filter_size) <= FILTER_DEPTH) && (int'(ifmap_size) <= IFMAP_DEPTH) &&
                  (filter_size <= ifmap_size);
  assign last_k = (int'(k) + 1 == int'(fs_q));
  assign last_f = (int'(f) == FILTER_NUM - 1);
  // The last output window is the one whose successor would run past the row.
  assign last_o = (int'(base) + int'(st_q) + int'(fs_q) > int'(is_q));
  assign prod   = $signed(fmem[FA_W'(int'(f) * int'(fs_q) + int'(k))]) *
                  $signed(imem[IA_W'(int'(base) + int'(k))]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    if (en) begin
      case (state)
        IDLE:    if (filter_wen && cfg_ok) next = LOAD_F;
        LOAD_F:  if (filter_done) next = WAIT_S;
        WAIT_S:  if (start) next = LOAD_I;
                 else if (!filter_done) next = IDLE;
        LOAD_I:  if (ifmap_wen && (int'(icnt) + 1 == int'(is_q))) next = MAC;
        MAC:     if (last_k) next = OUT;
        OUT:     if (psum_ready) next = (last_f && last_o) ? WAIT_S : MAC;
        default: next = IDLE;
      endcase
    end
  end

  always_comb begin
    filter_ready = (state == IDLE) ||
                   ((state == LOAD_F) && (int'(ptr) < FILTER_NUM * int'(fs_q)));
    ifmap_ready  = (state == LOAD_I) && (int'(icnt) < int'(is_q));
    busy         = (state != IDLE);
    dbg_state    = state;
  end

  assign psum_dout = acc;
  assign psum_fid  = f;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0; fs_q <= '0; is_q <= '0; st_q <= '0; cfg_err <= 1'b0;
      icnt <= '0; k <= '0; f <= '0; base <= '0; acc <= '0; psum_valid <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (filter_wen) begin
          if (cfg_ok) begin
            fs_q <= filter_size; is_q <= ifmap_size; st_q <= stride;
            ptr  <= PTR_W'(1);
          end else begin
            cfg_err <= 1'b1;
          end
        end
        LOAD_F: if (filter_wen && filter_ready) ptr <= ptr + PTR_W'(1);
        WAIT_S: if (start) icnt <= '0;
        LOAD_I: begin
          if (ifmap_wen && ifmap_ready) icnt <= icnt + 1'b1;
          k <= '0; f <= '0; base <= '0;
        end
        MAC: begin
          acc <= ((k == '0) ? '0 : acc) + PSUM_W'(prod);
          if (last_k) begin
            k          <= '0;
            psum_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: if (psum_ready) begin
          psum_valid <= 1'b0;
          if (last_f) begin
            f    <= '0;
            base <= base + (CONFIG_BIT+1)'(st_q);
          end else begin
            f <= f + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Scratchpads carry no reset; a fresh filter load zeroes every tap first.
  always_ff @(posedge clk) begin
    if (en) begin
      if (state == IDLE && filter_wen && cfg_ok) begin
        for (int i = 0; i < 2**FA_W; i++) fmem[i] <= '0;
        fmem[0] <= filter_din;
      end else if (state == LOAD_F && filter_wen && filter_ready) begin
        fmem[FA_W'(ptr)] <= filter_din;
      end
      if (state == LOAD_I && ifmap_wen && ifmap_ready) imem[IA_W'(icnt)] <= ifmap_din;
    end
  end

endmodule

// File: tb/tb_pe_conv1d_mf.sv
// Scoreboard bench for pe_conv1d_mf: a reference convolution model fills the expected
// queue when a row is fed, and the output monitor pops and compares each transfer.
module tb_pe_conv1d_mf;

  localparam int DW = 16, PW = 16, CB = 5, FN = 2, FD = 8, ID = 16, FID_W = 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd2, S_LOADI = 3'd3, S_MAC = 3'd4;

  logic          clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [CB-1:0] filter_size = '0, ifmap_size = '0, stride = '0;
  logic          filter_wen = 1'b0, filter_done = 1'b0, start = 1'b0, ifmap_wen = 1'b0;
  logic [DW-1:0] filter_din = '0, ifmap_din = '0;
  logic          filter_ready, ifmap_ready, psum_valid, busy, cfg_err;
  logic          psum_ready = 1'b0;
  logic [PW-1:0] psum_dout;
  logic [FID_W-1:0] psum_fid;
  logic [2:0]    dbg_state;

  pe_conv1d_mf #(.DATA_W(DW), .PSUM_W(PW), .CONFIG_BIT(CB), .FILTER_NUM(FN),
                 .FILTER_DEPTH(FD), .IFMAP_DEPTH(ID)) dut (
    .clk(clk), .rstn(rstn), .en(en), .filter_size(filter_size), .ifmap_size(ifmap_size),
    .stride(stride), .filter_wen(filter_wen), .filter_din(filter_din),
    .filter_ready(filter_ready), .filter_done(filter_done), .start(start),
    .ifmap_wen(ifmap_wen), .ifmap_din(ifmap_din), .ifmap_ready(ifmap_ready),
    .psum_dout(psum_dout), .psum_fid(psum_fid), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .busy(busy), .cfg_err(cfg_err), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  logic [PW+FID_W-1:0] exp_q[$];
  logic [DW-1:0] wsrc[32], xsrc[16], wm[16], xm[16];
  int total = 0, bad = 0;
  int cur_fs, cur_is, cur_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rstn && en && psum_valid && psum_ready) begin
      if (exp_q.size() == 0) chk("extra_psum", 0, 1);
      else chk("psum", {psum_fid, psum_dout}, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    rstn = 1'b0; en = 1'b1; filter_wen = 0; filter_done = 0; start = 0; ifmap_wen = 0;
    psum_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_expected();
    for (int b = 0; b + cur_fs <= cur_is; b += cur_st)
      for (int f = 0; f < FN; f++) begin
        int acc = 0;
        logic [PW-1:0] a16;
        for (int k = 0; k < cur_fs; k++)
          acc += int'($signed(wm[f*cur_fs+k])) * int'($signed(xm[b+k]));
        a16 = acc[PW-1:0];
        exp_q.push_back({f[FID_W-1:0], a16});
      end
  endtask

  task automatic load_filters(input int fs, input int is, input int st, input int n);
    filter_done = 1'b0; start = 1'b0; tick();
    for (int i = 0; i < 16; i++) wm[i] = '0;
    filter_size = CB'(fs); ifmap_size = CB'(is); stride = CB'(st);
    cur_fs = fs; cur_is = is; cur_st = st;
    filter_wen = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == FN * fs) chk("filter_full", filter_ready, 0);
      filter_din = wsrc[i];
      if (i < FN * fs) wm[i] = wsrc[i];
      tick();
    end
    filter_wen = 1'b0; filter_done = 1'b1; tick();
    chk("to_wait_s", dbg_state, S_WAIT);
  endtask

  task automatic feed_row();
    for (int i = 0; i < cur_is; i++) xm[i] = xsrc[i];
    push_expected();
    start = 1'b1; tick(); start = 1'b0;
    chk("to_load_i", dbg_state, S_LOADI);
    for (int i = 0; i < cur_is; ) begin
      logic w;
      w = ($urandom_range(0, 3) != 0);
      ifmap_wen = w; ifmap_din = xsrc[i];
      tick();
      if (w) i++;
    end
    ifmap_wen = 1'b0;
  endtask

  task automatic drain(input bit hold_first, input bit en_glitch);
    int cycles = 0;
    bit held = 0;
    while (!(dbg_state == S_WAIT && exp_q.size() == 0) && cycles < 3000) begin
      if (hold_first && !held && psum_valid) begin
        psum_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("hold_valid", psum_valid, 1);
          chk("hold_data", {psum_fid, psum_dout}, exp_q[0]);
        end
        held = 1;
      end
      psum_ready = ($urandom_range(0, 3) != 0);
      en = en_glitch ? ($urandom_range(0, 7) != 0) : 1'b1;
      tick();
      cycles++;
    end
    en = 1'b1; psum_ready = 1'b1;
    chk("row_timeout", cycles < 3000, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("end_wait_s", dbg_state, S_WAIT);
    exp_q.delete();
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_filter_ready"}, filter_ready, 1);
    chk({tag, "_ifmap_ready"}, ifmap_ready, 0);
    chk({tag, "_psum_valid"}, psum_valid, 0);
    chk({tag, "_psum_dout"}, psum_dout, 0);
    chk({tag, "_psum_fid"}, psum_fid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  task automatic cfg_bad(input int fs, input int is, input int st, input string tag);
    bit seen_valid = 0;
    do_reset();
    filter_size = CB'(fs); ifmap_size = CB'(is); stride = CB'(st);
    filter_wen = 1'b1; filter_din = 16'd5; tick(); filter_wen = 1'b0;
    chk({tag, "_cfg_err"}, cfg_err, 1);
    chk({tag, "_busy"}, busy, 0);
    filter_done = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (psum_valid || busy) seen_valid = 1;
    end
    filter_done = 1'b0; start = 1'b0;
    chk({tag, "_no_activity"}, seen_valid, 0);
    chk({tag, "_sticky"}, cfg_err, 1);
  endtask

  initial begin
    do_reset();
    reset_outputs("reset");

    // Single real filter {1,2,3,4}; the second filter slot stays zero.
    for (int i = 0; i < 4; i++) wsrc[i] = DW'(i + 1);
    for (int i = 0; i < 8; i++) xsrc[i] = DW'(i + 1);
    load_filters(4, 8, 1, 4);
    feed_row(); drain(1'b1, 1'b0);

    load_filters(4, 8, 2, 4);
    feed_row(); drain(1'b0, 1'b0);

    // Two filters plus one excess word that must be ignored.
    for (int i = 0; i < 4; i++) wsrc[i] = DW'(i + 1);
    for (int i = 4; i < 8; i++) wsrc[i] = 16'd1;
    wsrc[8] = 16'd99;
    load_filters(4, 8, 1, 9);
    feed_row(); drain(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) xsrc[i] = DW'($urandom_range(0, 65535));
    feed_row(); drain(1'b0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      int fs, is, st;
      fs = $urandom_range(1, FD); is = $urandom_range(fs, ID); st = $urandom_range(1, 4);
      if (t == 0) begin fs = FD; is = ID; st = 1; end
      for (int i = 0; i < 2 * fs; i++) wsrc[i] = DW'($urandom_range(0, 65535));
      load_filters(fs, is, st, 2 * fs);
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < 16; i++) xsrc[i] = DW'($urandom_range(0, 65535));
        feed_row(); drain(1'b0, r == 1);
      end
    end

    cfg_bad(0, 8, 1, "fs_zero");
    cfg_bad(9, 12, 1, "fs_over");
    cfg_bad(4, 8, 0, "st_zero");

    // Asynchronous reset while accumulating, then a clean reload.
    do_reset();
    for (int i = 0; i < 4; i++) wsrc[i] = DW'(i + 1);
    for (int i = 0; i < 8; i++) xsrc[i] = DW'(i + 1);
    load_filters(4, 8, 1, 4);
    feed_row();
    chk("in_mac", dbg_state, S_MAC);
    tick();
    #2 rstn = 1'b0;
    #1 reset_outputs("midmac");
    exp_q.delete();
    tick(); rstn = 1'b1; filter_done = 1'b0;
    load_filters(4, 8, 1, 4);
    feed_row(); drain(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
